// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared widths and grant encoding for the regfile write path
package proc_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int ENTRY_W    = REG_ADDR_W + DATA_W;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_EXT  = 2'd2
   } grant_t;

endpackage

// File: rtl/wb_req_fifo.sv
// rtl/wb_req_fifo.sv - synchronous FIFO of buffered {rd, data} write requests
module wb_req_fifo
   import proc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = ENTRY_W
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             pushData,
   input  logic                     pop,
   output logic [W-1:0]             headData,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic          doPush;
   logic          doPop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign doPush   = push && !full;
   assign doPop    = pop && !empty;
   assign headData = mem[rdPtr];

   // Storage array; contents are don't-care until written, so it has no reset.
   always_ff @(posedge clock) begin
      if (doPush) begin
         mem[wrPtr] <= pushData;
      end
   end

   // Pointers wrap naturally at DEPTH (power of 2); occupancy tracks push/pop.
   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + AW'(1);
         if (doPop)  rdPtr <= rdPtr + AW'(1);
         if (doPush && !doPop)      count <= count + CW'(1);
         else if (doPop && !doPush) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the regfile write port between CPU writeback and the boid engine
module regfile_write_arbiter
   import proc_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_WAIT   = 8
) (
   input  logic                        clock,
   input  logic                        ctrl_reset,
   input  logic                        cpu_we,
   input  logic [REG_ADDR_W-1:0]       cpu_rd,
   input  logic [DATA_W-1:0]           cpu_data,
   output logic                        cpu_stall,
   input  logic                        ext_valid,
   output logic                        ext_ready,
   input  logic [REG_ADDR_W-1:0]       ext_rd,
   input  logic [DATA_W-1:0]           ext_data,
   output logic                        ctrl_writeEnable,
   output logic [REG_ADDR_W-1:0]       ctrl_writeReg,
   output logic [DATA_W-1:0]           data_writeReg,
   output logic [$clog2(FIFO_DEPTH):0] ext_pending,
   output logic                        ext_granted
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int WW = $clog2(MAX_WAIT + 1);

   logic               cpuEff;
   logic               forceExt;
   logic               fifoPush;
   logic               fifoPop;
   logic               fifoFull;
   logic               fifoEmpty;
   logic [CW-1:0]      fifoCount;
   logic [ENTRY_W-1:0] headData;
   logic [WW-1:0]      waitCnt;
   grant_t             grant;

   // A CPU write to r0 is architecturally a no-op, so it never claims the port.
   assign cpuEff   = cpu_we && (cpu_rd != '0);
   assign forceExt = (waitCnt == WW'(MAX_WAIT)) && !fifoEmpty;

   // r0 pushes complete the handshake but are dropped rather than stored.
   assign fifoPush = ext_valid && !fifoFull && (ext_rd != '0) && !ctrl_reset;
   assign fifoPop  = (grant == GNT_EXT) && !ctrl_reset;

   wb_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clock    (clock),
      .reset    (ctrl_reset),
      .push     (fifoPush),
      .pushData ({ext_rd, ext_data}),
      .pop      (fifoPop),
      .headData (headData),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCount)
   );

   // Priority select: starved ext head, then CPU, then any pending ext entry.
   always_comb begin
      grant = GNT_NONE;
      if (forceExt)        grant = GNT_EXT;
      else if (cpuEff)     grant = GNT_CPU;
      else if (!fifoEmpty) grant = GNT_EXT;
   end

   // Port drive and status; everything reads as zero while reset is held.
   always_comb begin
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = '0;
      data_writeReg    = '0;
      cpu_stall        = 1'b0;
      ext_ready        = 1'b0;
      ext_pending      = '0;
      ext_granted      = 1'b0;
      if (!ctrl_reset) begin
         cpu_stall   = forceExt && cpuEff;
         ext_ready   = !fifoFull;
         ext_pending = fifoCount;
         case (grant)
            GNT_CPU: begin
               ctrl_writeEnable = 1'b1;
               ctrl_writeReg    = cpu_rd;
               data_writeReg    = cpu_data;
            end
            GNT_EXT: begin
               ctrl_writeEnable = 1'b1;
               ctrl_writeReg    = headData[ENTRY_W-1 -: REG_ADDR_W];
               data_writeReg    = headData[DATA_W-1:0];
               ext_granted      = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Count consecutive cycles the ext head is denied, saturating at MAX_WAIT.
   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         waitCnt <= '0;
      end else if ((grant == GNT_EXT) || fifoEmpty) begin
         waitCnt <= '0;
      end else if (waitCnt != WW'(MAX_WAIT)) begin
         waitCnt <= waitCnt + WW'(1);
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

   localparam int DEPTH = 4;
   localparam int MAXW  = 8;

   logic        clock;
   logic        ctrl_reset;
   logic        cpu_we;
   logic [4:0]  cpu_rd;
   logic [31:0] cpu_data;
   logic        cpu_stall;
   logic        ext_valid;
   logic        ext_ready;
   logic [4:0]  ext_rd;
   logic [31:0] ext_data;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [2:0]  ext_pending;
   logic        ext_granted;

   regfile_write_arbiter #(
      .FIFO_DEPTH (DEPTH),
      .MAX_WAIT   (MAXW)
   ) dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .cpu_we           (cpu_we),
      .cpu_rd           (cpu_rd),
      .cpu_data         (cpu_data),
      .cpu_stall        (cpu_stall),
      .ext_valid        (ext_valid),
      .ext_ready        (ext_ready),
      .ext_rd           (ext_rd),
      .ext_data         (ext_data),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .ext_pending      (ext_pending),
      .ext_granted      (ext_granted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic        stall;
      logic        ready;
      logic [2:0]  pending;
      logic        granted;
   } exp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } req_t;

   exp_t expQ[$];
   req_t pendQ[$];
   int   starve;
   logic lastStall;
   int   vectors;
   int   miscompares;

   // Reference model: a queue of accepted requests and a streak of denied cycles.
   task automatic step(input logic rst, input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic ev, input logic [4:0] erd, input logic [31:0] ed);
      exp_t e;
      logic cpuWants;
      logic extFirst;
      logic extWins;
      logic accepted;
      ctrl_reset = rst;
      cpu_we = we; cpu_rd = rd; cpu_data = d;
      ext_valid = ev; ext_rd = erd; ext_data = ed;
      e = '{we: 1'b0, wreg: 5'd0, wdata: 32'd0, stall: 1'b0, ready: 1'b0, pending: 3'd0, granted: 1'b0};
      if (rst) begin
         pendQ.delete();
         starve = 0;
      end else begin
         cpuWants = we && (rd != 5'd0);
         extFirst = (starve >= MAXW) && (pendQ.size() > 0);
         extWins  = extFirst || (!cpuWants && pendQ.size() > 0);
         accepted = ev && (pendQ.size() < DEPTH);
         e.ready   = pendQ.size() < DEPTH;
         e.pending = 3'(pendQ.size());
         e.stall   = extFirst && cpuWants;
         if (extWins) begin
            e.we = 1'b1; e.wreg = pendQ[0].rd; e.wdata = pendQ[0].data; e.granted = 1'b1;
         end else if (cpuWants) begin
            e.we = 1'b1; e.wreg = rd; e.wdata = d;
         end
         if (extWins || pendQ.size() == 0) starve = 0;
         else if (starve < MAXW) starve++;
         if (extWins) void'(pendQ.pop_front());
         if (accepted && erd != 5'd0) pendQ.push_back('{rd: erd, data: ed});
      end
      lastStall = e.stall;
      expQ.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: one expected record per clock, compared mid-cycle.
   always @(negedge clock) begin
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         vectors++;
         check("writeEnable", 32'(ctrl_writeEnable), 32'(e.we));
         check("writeReg",    32'(ctrl_writeReg),    32'(e.wreg));
         check("writeData",   data_writeReg,         e.wdata);
         check("cpu_stall",   32'(cpu_stall),        32'(e.stall));
         check("ext_ready",   32'(ext_ready),        32'(e.ready));
         check("ext_pending", 32'(ext_pending),      32'(e.pending));
         check("ext_granted", 32'(ext_granted),      32'(e.granted));
      end
   end

   initial begin
      logic [4:0]  rRd;
      logic [31:0] rData;
      logic        rWe;
      vectors = 0; miscompares = 0; starve = 0; lastStall = 1'b0;
      ctrl_reset = 1'b1; cpu_we = 1'b0; cpu_rd = '0; cpu_data = '0;
      ext_valid = 1'b0; ext_rd = '0; ext_data = '0;
      @(posedge clock);
      #1;

      // Reset then idle
      repeat (2) step(1, 0, 0, 0, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);

      // CPU only, including a write to r0
      step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
      step(0, 1, 0, 32'h12345678, 0, 0, 0);

      // Ext only
      step(0, 0, 0, 0, 1, 25, 32'h10);
      step(0, 0, 0, 0, 1, 26, 32'h20);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0);

      // Starvation: CPU busy every cycle
      step(0, 1, 3, 32'hC0, 1, 27, 32'h55);
      repeat (14) step(0, 1, 3, 32'hC0, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);

      // Full FIFO with CPU busy
      for (int i = 0; i < 6; i++) step(0, 1, 4, 32'(i), 1, 28, 32'h100 + 32'(i));
      repeat (8) step(0, 0, 0, 0, 0, 0, 0);

      // Push to r0 is swallowed
      step(0, 0, 0, 0, 1, 0, 32'hBAD);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);

      // Reset with three entries pending
      for (int i = 0; i < 3; i++) step(0, 1, 6, 32'(i), 1, 29, 32'h200 + 32'(i));
      step(1, 0, 0, 0, 0, 0, 0);
      repeat (4) step(0, 0, 0, 0, 0, 0, 0);

      // Random traffic; a stalled CPU write is re-presented unchanged
      rWe = 0; rRd = 0; rData = 0;
      for (int i = 0; i < 600; i++) begin
         if (!lastStall) begin
            rWe   = ($urandom_range(0, 3) != 0);
            rRd   = 5'($urandom_range(0, 31));
            rData = $urandom;
         end
         step(($urandom_range(0, 99) == 0), rWe, rRd, rData,
              ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom);
      end
      repeat (6) step(0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
